apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single APB master bridge between two requesters: port 0 (GPIO client) and port 1 (UART client).
- Captures one request, drives the bridge's transfer/address/data/write inputs, and watches PSEL/PENABLE/PREADY on the bus to detect completion.
- Returns read data, a done pulse and an error flag to the owning requester.
- Provides a timeout abort when the slave stalls.

Parameters:
- ADDR_W, 4, address width, matches bridge PADDR.
- DATA_W, 8, data width, matches bridge PWDATA/PRDATA.
- TIMEOUT_CYC, 16, maximum cycles from grant to completion before abort; legal range 4..255.

Ports:
- PCLK  in  1  bus clock; all logic on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request; held high until req0_done.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  target address.
- req0_wdata  in  DATA_W  write data.
- req0_gnt  out  1  port 0 owns the bridge.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data; valid when req0_done is high.
- req0_err  out  1  timeout flag; valid when req0_done is high.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_gnt, req1_done, req1_rdata, req1_err: same as port 0, for port 1.
- transfer  out  1  to bridge transfer.
- PADDR_master  out  ADDR_W  to bridge.
- PWRITE_master  out  1  to bridge.
- PWDATA_master  out  DATA_W  to bridge.
- PSEL  in  1  observed bus select.
- PENABLE  in  1  observed bus enable.
- PREADY  in  1  observed slave ready.
- PRDATA  in  DATA_W  observed slave read data.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; timer 0; last_grant = 1, so port 0 wins the first tie.
- PRESET mid-operation: every register returns to its reset value at that edge and no done pulse is issued. The bridge is reset by the same reset.

States and transitions:
- IDLE: if any valid is high, pick a winner.
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - At the same edge: latch the winner's addr/wdata/write into PADDR_master/PWDATA_master/PWRITE_master; set gnt[winner]=1, transfer=1, last_grant=winner, timer=0; go to SETUP_WAIT.
- SETUP_WAIT: transfer stays 1. When PSEL & PENABLE are sampled high, set transfer=0 and go to ACCESS_WAIT. Transfer is low before the slave's PREADY, so the bridge returns to its idle state, not back-to-back setup.
- ACCESS_WAIT: completion when PSEL & PENABLE & PREADY are sampled high.
  - Set done[owner]=1 and err[owner]=0.
  - On a read, rdata[owner]=PRDATA; on a write, rdata[owner] keeps its old value.
  - Set gnt=0 and go to GAP.
  - If PSEL & PENABLE & PREADY are already high at the SETUP_WAIT edge, completion is taken in SETUP_WAIT with the same actions, and the machine goes straight to GAP.
- Timeout: timer increments every cycle in SETUP_WAIT and ACCESS_WAIT. When timer == TIMEOUT_CYC-1 with no completion at that edge:
  - Set done[owner]=1, err[owner]=1, rdata[owner]=0, transfer=0, gnt=0; go to GAP.
  - Completion and timeout at the same edge: completion wins, err=0.
- GAP: one cycle. done drops to 0; requests are ignored; go to IDLE. Requesters must drop valid in the cycle after done; a valid still high at the next IDLE is a new request.
- Only the owner's done/err/rdata change. The other port's rdata holds.
- Request fields changing while gnt is high have no effect; values were latched at grant.
- Latency: gnt and transfer are high 1 cycle after valid is sampled in IDLE. The minimum request-to-request spacing for one port is grant + bridge cycles + GAP.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1.

Test Plan:
- Single write, zero wait states: req0 write addr=4'h3 wdata=8'hA5 -> PADDR_master=3, PWDATA_master=A5, PWRITE_master=1 one cycle after valid; transfer falls when PENABLE is seen; req0_done pulses once with req0_err=0; req1 outputs stay 0.
- Single read with 3 wait states: slave PREADY low 3 access cycles, PRDATA=8'h5C -> req1_done pulses on the PREADY cycle, req1_rdata=5C, transfer low during the wait.
- Simultaneous requests after reset: both valid at the same edge -> port 0 granted first, then port 1 after GAP. Repeated 4 times with both held valid -> grant order 0,1,0,1,0,1,0,1.
- Timeout: TIMEOUT_CYC=8, slave never raises PREADY -> done pulses on the 8th cycle after grant with err=1 and rdata=0; arbiter returns to IDLE and the next request is served normally.
- Reset mid-transfer: assert PRESET in ACCESS_WAIT -> next edge all outputs 0, no done pulse, last_grant=1; a fresh req0 then completes normally.
- Completion on the timeout edge: PREADY first high exactly at cycle TIMEOUT_CYC-1 -> done with err=0 and the correct PRDATA.

Source files
------------

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : apb_req_arbiter
// Purpose : Round-robin arbiter and sequencer that shares one APB master
//           bridge between two requesters (port 0 = GPIO client, port 1 =
//           UART client).  It captures one request, drives the bridge's
//           transfer/address/data/write inputs, watches PSEL/PENABLE/PREADY
//           for completion, and returns rdata/done/err to the owner.  A
//           grant-to-completion timer aborts stalled transfers.
// Ports   : PCLK, PRESET (sync, active-high)
//           reqN_valid/write/addr/wdata   requester inputs (N = 0,1)
//           reqN_gnt/done/rdata/err       requester outputs (all registered)
//           transfer, PADDR_master, PWRITE_master, PWDATA_master -> bridge
//           PSEL, PENABLE, PREADY, PRDATA <- observed APB bus
// Revision: 1.0  initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_gnt,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_gnt,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              transfer,
    output logic [ADDR_W-1:0] PADDR_master,
    output logic              PWRITE_master,
    output logic [DATA_W-1:0] PWDATA_master,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_SETUP_WAIT  = 2'd1;
    localparam logic [1:0] c_ACCESS_WAIT = 2'd2;
    localparam logic [1:0] c_GAP         = 2'd3;

    localparam logic [7:0] c_TIMER_LAST  = 8'(TIMEOUT_CYC - 1);

    logic [1:0]             r_state,      w_state_nxt;
    logic [7:0]             r_timer,      w_timer_nxt;
    logic                   r_last_grant, w_last_grant_nxt;
    logic                   r_owner,      w_owner_nxt;
    logic [1:0]             r_gnt,        w_gnt_nxt;
    logic [1:0]             r_done,       w_done_nxt;
    logic [1:0]             r_err,        w_err_nxt;
    logic [1:0][DATA_W-1:0] r_rdata,      w_rdata_nxt;
    logic                   r_transfer,   w_transfer_nxt;
    logic [ADDR_W-1:0]      r_paddr,      w_paddr_nxt;
    logic                   r_pwrite,     w_pwrite_nxt;
    logic [DATA_W-1:0]      r_pwdata,     w_pwdata_nxt;

    logic w_winner;
    logic w_complete;
    logic w_timeout;

    assign w_complete = PSEL & PENABLE & PREADY;
    assign w_timeout  = (r_timer == c_TIMER_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_last_grant_nxt = r_last_grant;
        w_owner_nxt      = r_owner;
        w_gnt_nxt        = r_gnt;
        w_done_nxt       = 2'b00;           // done is a single-cycle pulse
        w_err_nxt        = r_err;
        w_rdata_nxt      = r_rdata;
        w_transfer_nxt   = r_transfer;
        w_paddr_nxt      = r_paddr;
        w_pwrite_nxt     = r_pwrite;
        w_pwdata_nxt     = r_pwdata;
        w_winner         = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (req0_valid | req1_valid) begin
                    // On a tie the port that did not win last time goes next.
                    if (req0_valid & req1_valid) w_winner = ~r_last_grant;
                    else                         w_winner = req1_valid;
                    w_paddr_nxt          = w_winner ? req1_addr  : req0_addr;
                    w_pwdata_nxt         = w_winner ? req1_wdata : req0_wdata;
                    w_pwrite_nxt         = w_winner ? req1_write : req0_write;
                    w_gnt_nxt            = 2'b00;
                    w_gnt_nxt[w_winner]  = 1'b1;
                    w_transfer_nxt       = 1'b1;
                    w_last_grant_nxt     = w_winner;
                    w_owner_nxt          = w_winner;
                    w_timer_nxt          = 8'd0;
                    w_state_nxt          = c_SETUP_WAIT;
                end
            end
            c_SETUP_WAIT, c_ACCESS_WAIT: begin
                w_timer_nxt = r_timer + 8'd1;
                if (w_complete) begin
                    // A zero-wait slave may complete while still in SETUP_WAIT.
                    w_done_nxt[r_owner] = 1'b1;
                    w_err_nxt[r_owner]  = 1'b0;
                    if (!r_pwrite) w_rdata_nxt[r_owner] = PRDATA;
                    w_gnt_nxt           = 2'b00;
                    w_transfer_nxt      = 1'b0;
                    w_state_nxt         = c_GAP;
                end else if (w_timeout) begin
                    w_done_nxt[r_owner]  = 1'b1;
                    w_err_nxt[r_owner]   = 1'b1;
                    w_rdata_nxt[r_owner] = '0;
                    w_gnt_nxt            = 2'b00;
                    w_transfer_nxt       = 1'b0;
                    w_state_nxt          = c_GAP;
                end else if ((r_state == c_SETUP_WAIT) && PSEL && PENABLE) begin
                    // Drop transfer before PREADY so the bridge returns to
                    // idle instead of starting a back-to-back setup phase.
                    w_transfer_nxt = 1'b0;
                    w_state_nxt    = c_ACCESS_WAIT;
                end
            end
            c_GAP: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= c_IDLE;
            r_timer      <= 8'd0;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_gnt        <= 2'b00;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
            r_rdata      <= '0;
            r_transfer   <= 1'b0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_rdata      <= w_rdata_nxt;
            r_transfer   <= w_transfer_nxt;
            r_paddr      <= w_paddr_nxt;
            r_pwrite     <= w_pwrite_nxt;
            r_pwdata     <= w_pwdata_nxt;
        end
    end

    assign req0_gnt      = r_gnt[0];
    assign req1_gnt      = r_gnt[1];
    assign req0_done     = r_done[0];
    assign req1_done     = r_done[1];
    assign req0_err      = r_err[0];
    assign req1_err      = r_err[1];
    assign req0_rdata    = r_rdata[0];
    assign req1_rdata    = r_rdata[1];
    assign transfer      = r_transfer;
    assign PADDR_master  = r_paddr;
    assign PWRITE_master = r_pwrite;
    assign PWDATA_master = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_req_arbiter
// Purpose : Self-checking bench for apb_req_arbiter.  A transaction-level
//           model predicts every registered output each cycle; a simple
//           bridge/slave model answers the bus.  Directed scenarios pin
//           literal values, then randomized traffic runs against the model.
// Revision: 1.0  initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req0_valid, req0_write, req0_gnt, req0_done, req0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_write, req1_gnt, req1_done, req1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    logic              transfer, PWRITE_master;
    logic [ADDR_W-1:0] PADDR_master;
    logic [DATA_W-1:0] PWDATA_master;
    logic              PSEL, PENABLE, PREADY;
    logic [DATA_W-1:0] PRDATA;

    apb_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_gnt(req0_gnt), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_gnt(req1_gnt), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .transfer(transfer), .PADDR_master(PADDR_master),
        .PWRITE_master(PWRITE_master), .PWDATA_master(PWDATA_master),
        .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Requester / slave stimulus settings
    bit                drv_v[2];
    bit                drv_w[2];
    logic [ADDR_W-1:0] drv_a[2];
    logic [DATA_W-1:0] drv_d[2];
    bit                drv_rst;
    int                slave_wait;
    logic [DATA_W-1:0] slave_data;
    bit                rand_mode;

    // Bridge model: 0 idle, 1 setup, 2 access; br_cnt = access cycles so far
    int br_state;
    int br_cnt;

    // Transaction-level arbiter model
    int                m_owner;     // -1 when nobody holds the bridge
    int                m_age;       // edges spent waiting since the grant
    int                m_last;
    bit                m_gap;
    bit                m_timeout_evt;
    bit                e_gnt[2], e_done[2], e_err[2];
    logic [DATA_W-1:0] e_rdata[2];
    bit                e_transfer, e_pwrite;
    logic [ADDR_W-1:0] e_paddr;
    logic [DATA_W-1:0] e_pwdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_last = 1; m_gap = 0;
        for (int p = 0; p < 2; p++) begin
            e_gnt[p] = 0; e_done[p] = 0; e_err[p] = 0; e_rdata[p] = '0;
        end
        e_transfer = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
    endtask

    // Predicts the outputs after the coming edge from the inputs now driven.
    task automatic model_step();
        bit v0, v1, compl;
        int w;
        m_timeout_evt = 0;
        if (PRESET) begin
            model_reset();
            return;
        end
        e_done[0] = 0;
        e_done[1] = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_owner < 0) begin
            v0 = req0_valid;
            v1 = req1_valid;
            if (v0 || v1) begin
                w = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
                m_owner = w; m_last = w; m_age = 0;
                e_gnt[w]   = 1;
                e_transfer = 1;
                e_paddr    = (w == 1) ? req1_addr  : req0_addr;
                e_pwdata   = (w == 1) ? req1_wdata : req0_wdata;
                e_pwrite   = (w == 1) ? req1_write : req0_write;
            end
        end else begin
            compl = PSEL && PENABLE && PREADY;
            if (compl || m_age == TIMEOUT_CYC - 1) begin
                e_done[m_owner] = 1;
                e_err[m_owner]  = !compl;
                if (!compl)         e_rdata[m_owner] = '0;
                else if (!e_pwrite) e_rdata[m_owner] = PRDATA;
                e_gnt[m_owner] = 0;
                e_transfer     = 0;
                m_owner        = -1;
                m_gap          = 1;
                m_timeout_evt  = !compl;
            end else begin
                if (PSEL && PENABLE) e_transfer = 0;
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        check("gnt0", 32'(req0_gnt), 32'(e_gnt[0]));
        check("gnt1", 32'(req1_gnt), 32'(e_gnt[1]));
        check("done0", 32'(req0_done), 32'(e_done[0]));
        check("done1", 32'(req1_done), 32'(e_done[1]));
        if (e_done[0]) check("err0", 32'(req0_err), 32'(e_err[0]));
        if (e_done[1]) check("err1", 32'(req1_err), 32'(e_err[1]));
        check("rdata0", 32'(req0_rdata), 32'(e_rdata[0]));
        check("rdata1", 32'(req1_rdata), 32'(e_rdata[1]));
        check("transfer", 32'(transfer), 32'(e_transfer));
        if (e_gnt[0] || e_gnt[1]) begin
            check("paddr", 32'(PADDR_master), 32'(e_paddr));
            check("pwdata", 32'(PWDATA_master), 32'(e_pwdata));
            check("pwrite", 32'(PWRITE_master), 32'(e_pwrite));
        end
    endtask

    task automatic rand_requesters();
        for (int p = 0; p < 2; p++) begin
            if (drv_v[p] && e_done[p]) begin
                drv_v[p] = 0;
            end else if (!drv_v[p]) begin
                if ($urandom_range(0, 3) == 0) begin
                    drv_v[p] = 1;
                    drv_w[p] = 1'($urandom_range(0, 1));
                    drv_a[p] = ADDR_W'($urandom);
                    drv_d[p] = DATA_W'($urandom);
                end
            end else if (e_gnt[p] && $urandom_range(0, 1) == 1) begin
                // Fields wiggling after the grant must not reach the bridge.
                drv_w[p] = 1'($urandom_range(0, 1));
                drv_a[p] = ADDR_W'($urandom);
                drv_d[p] = DATA_W'($urandom);
            end
        end
        drv_rst = ($urandom_range(0, 149) == 0);
    endtask

    // One clock: check outputs, drive inputs for the next edge, advance models.
    task automatic cycle();
        int nb, nc;
        @(negedge PCLK);
        compare_all();
        if (rand_mode) rand_requesters();
        PRESET     = drv_rst;
        req0_valid = drv_v[0]; req0_write = drv_w[0]; req0_addr = drv_a[0]; req0_wdata = drv_d[0];
        req1_valid = drv_v[1]; req1_write = drv_w[1]; req1_addr = drv_a[1]; req1_wdata = drv_d[1];
        PSEL    = (br_state != 0);
        PENABLE = (br_state == 2);
        PREADY  = (br_state == 2) && (br_cnt >= slave_wait);
        PRDATA  = PREADY ? slave_data : DATA_W'($urandom);
        nb = br_state;
        nc = br_cnt;
        if (PRESET) nb = 0;
        else begin
            case (br_state)
                0: if (e_transfer) begin
                       nb = 1;
                       if (rand_mode) begin
                           slave_wait = int'($urandom_range(0, 7));
                           slave_data = DATA_W'($urandom);
                       end
                   end
                1: begin nb = 2; nc = 0; end
                default: if (PREADY) nb = 0; else nc = br_cnt + 1;
            endcase
        end
        model_step();
        if (m_timeout_evt) nb = 0;   // stalled slave is abandoned on abort
        br_state = nb;
        br_cnt   = nc;
    endtask

    function automatic bit ev_of(input int p, input bit want_done);
        if (want_done) return (p == 1) ? req1_done : req0_done;
        return (p == 1) ? req1_gnt : req0_gnt;
    endfunction

    task automatic wait_for(input string name, input int p, input bit want_done, output int k);
        k = 0;
        while (k < 40) begin
            cycle();
            k++;
            if (ev_of(p, want_done)) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not seen within %0d cycles", name, k);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int order[$];
        bit p0, p1;

        PRESET = 1; PSEL = 0; PENABLE = 0; PREADY = 0; PRDATA = '0;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        for (int p = 0; p < 2; p++) begin
            drv_v[p] = 0; drv_w[p] = 0; drv_a[p] = '0; drv_d[p] = '0;
        end
        drv_rst = 1; rand_mode = 0; slave_wait = 0; slave_data = '0;
        br_state = 0; br_cnt = 0;
        model_reset();

        // Reset state
        idle_cycles(2);
        check("rst_gnt0", 32'(req0_gnt), 32'd0);
        check("rst_transfer", 32'(transfer), 32'd0);
        check("rst_paddr", 32'(PADDR_master), 32'd0);
        drv_rst = 0;
        idle_cycles(2);

        // Single write, zero wait states, port 0
        drv_v[0] = 1; drv_w[0] = 1; drv_a[0] = 4'h3; drv_d[0] = 8'hA5; slave_wait = 0;
        wait_for("wr_gnt", 0, 0, k);
        check("wr_gnt_latency", 32'(k), 32'd2);
        check("wr_paddr", 32'(PADDR_master), 32'h3);
        check("wr_pwdata", 32'(PWDATA_master), 32'hA5);
        check("wr_pwrite", 32'(PWRITE_master), 32'd1);
        check("wr_transfer", 32'(transfer), 32'd1);
        wait_for("wr_done", 0, 1, k);
        check("wr_done_latency", 32'(k), 32'd3);
        check("wr_err", 32'(req0_err), 32'd0);
        check("wr_transfer_low", 32'(transfer), 32'd0);
        check("wr_req1_done", 32'(req1_done), 32'd0);
        drv_v[0] = 0;
        cycle();
        check("wr_done_once", 32'(req0_done), 32'd0);
        idle_cycles(2);

        // Single read with 3 wait states, port 1
        drv_v[1] = 1; drv_w[1] = 0; drv_a[1] = 4'h7; slave_wait = 3; slave_data = 8'h5C;
        wait_for("rd_gnt", 1, 0, k);
        for (k = 1; k <= 10; k++) begin
            cycle();
            if (k == 4) check("rd_transfer_wait", 32'(transfer), 32'd0);
            if (req1_done) break;
        end
        check("rd_done_latency", 32'(k), 32'd6);
        check("rd_rdata", 32'(req1_rdata), 32'h5C);
        check("rd_err", 32'(req1_err), 32'd0);
        check("rd_req0_rdata_hold", 32'(req0_rdata), 32'd0);
        drv_v[1] = 0;
        idle_cycles(3);

        // Fairness after reset with both held valid
        drv_rst = 1;
        cycle();
        drv_rst = 0;
        drv_v[0] = 1; drv_w[0] = 0; drv_a[0] = 4'h1;
        drv_v[1] = 1; drv_w[1] = 0; drv_a[1] = 4'h2;
        slave_wait = 1; slave_data = 8'h3C;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 300 && order.size() < 8; i++) begin
            cycle();
            if (req0_gnt && !p0) order.push_back(0);
            if (req1_gnt && !p1) order.push_back(1);
            p0 = req0_gnt;
            p1 = req1_gnt;
        end
        check("fair_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
        drv_v[0] = 0; drv_v[1] = 0;
        idle_cycles(12);
        check("fair_rdata0", 32'(req0_rdata), 32'h3C);

        // Timeout: slave never ready
        drv_v[0] = 1; drv_w[0] = 0; drv_a[0] = 4'h9; slave_wait = 1000;
        wait_for("to_gnt", 0, 0, k);
        wait_for("to_done", 0, 1, k);
        check("to_latency", 32'(k), 32'(TIMEOUT_CYC));
        check("to_err", 32'(req0_err), 32'd1);
        check("to_rdata", 32'(req0_rdata), 32'd0);
        drv_v[0] = 0;
        idle_cycles(2);
        drv_v[1] = 1; drv_w[1] = 0; drv_a[1] = 4'h4; slave_wait = 0; slave_data = 8'h91;
        wait_for("after_to_done", 1, 1, k);
        check("after_to_err", 32'(req1_err), 32'd0);
        check("after_to_rdata", 32'(req1_rdata), 32'h91);
        drv_v[1] = 0;
        idle_cycles(2);

        // Completion exactly on the timeout edge
        drv_v[0] = 1; drv_w[0] = 0; drv_a[0] = 4'hB; slave_wait = 5; slave_data = 8'hE7;
        wait_for("edge_gnt", 0, 0, k);
        wait_for("edge_done", 0, 1, k);
        check("edge_latency", 32'(k), 32'(TIMEOUT_CYC));
        check("edge_err", 32'(req0_err), 32'd0);
        check("edge_rdata", 32'(req0_rdata), 32'hE7);
        drv_v[0] = 0;
        idle_cycles(2);

        // Reset in the middle of an access
        drv_v[0] = 1; drv_w[0] = 0; drv_a[0] = 4'h6; slave_wait = 1000;
        wait_for("mid_gnt", 0, 0, k);
        idle_cycles(4);
        drv_rst = 1;
        cycle();
        cycle();
        check("mid_gnt0", 32'(req0_gnt), 32'd0);
        check("mid_done0", 32'(req0_done), 32'd0);
        check("mid_transfer", 32'(transfer), 32'd0);
        check("mid_rdata0", 32'(req0_rdata), 32'd0);
        check("mid_pwrite", 32'(PWRITE_master), 32'd0);
        drv_rst = 0;
        drv_v[1] = 1; drv_w[1] = 1; drv_a[1] = 4'h5; drv_d[1] = 8'h11;
        slave_wait = 0; slave_data = 8'h2D;
        wait_for("post_rst_gnt", 0, 0, k);
        check("post_rst_winner1", 32'(req1_gnt), 32'd0);
        wait_for("post_rst_done", 0, 1, k);
        check("post_rst_err", 32'(req0_err), 32'd0);
        check("post_rst_rdata", 32'(req0_rdata), 32'h2D);
        drv_v[0] = 0;
        wait_for("post_rst_done1", 1, 1, k);
        drv_v[1] = 0;
        idle_cycles(3);

        // Randomized traffic against the model
        rand_mode = 1;
        idle_cycles(3000);
        rand_mode = 0;
        drv_rst = 0;
        drv_v[0] = 0;
        drv_v[1] = 0;
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
